pol_max_unit: RTL
=================

Name: pol_max_unit

Overview:
- One pooling core; POOL_CORE instances sit directly upstream of the multi-core pool address arbiter.
- Takes a stream of neighbour map indices and issues one GLB address per index through the arbiter's per-core addr port.
- Consumes the returned ofm vectors in order and computes a channel-wise max over each group of K neighbours.
- Emits one pooled vector per output point to GLB.

Parameters:
- IDX_WIDTH, 10, index/address width and point-count width
- ACT_WIDTH, 8, activation width per channel
- POOL_COMP_CORE, 64, channels per ofm vector
- NBR_WIDTH, 5, width of neighbour count K
- MAX_OUTSTD, 4, max address requests in flight awaiting ofm return

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- CCUPOL_Rst  in  1  synchronous clear, same effect as reset
- CCUPOL_CfgVld  in  1  start-of-layer config valid
- CCUPOL_CfgK  in  NBR_WIDTH  neighbours per point; 0 is treated as 1
- CCUPOL_CfgNp  in  IDX_WIDTH  output points in the layer; 0 completes immediately
- POLCCU_CfgRdy  out  1  high in IDLE
- POLCCU_Done  out  1  one-cycle pulse at end of layer
- MAPPOL_IdxVld  in  1  neighbour index valid
- MAPPOL_Idx  in  IDX_WIDTH  neighbour index
- POLMAP_IdxRdy  out  1  index accepted
- POLMIF_AddrVld  out  1  address request valid
- POLMIF_Addr  out  IDX_WIDTH  address, equal to MAPPOL_Idx
- MIFPOL_AddrRdy  in  1  arbiter accept (grant & !full)
- MIFPOL_OfmVld  in  1  returned vector valid
- MIFPOL_Ofm  in  ACT_WIDTH*POOL_COMP_CORE  returned vector
- POLMIF_OfmRdy  out  1  returned vector accepted
- POLGLB_OfmVld  out  1  pooled vector valid
- POLGLB_Ofm  out  ACT_WIDTH*POOL_COMP_CORE  pooled vector
- GLBPOL_OfmRdy  in  1  pooled vector accepted

Behaviour:
- Reset and CCUPOL_Rst:
  - State goes to IDLE; all counters, accumulator and output register clear.
  - Outputs reset to 0, except POLCCU_CfgRdy = 1.
  - Reset mid-layer abandons in-flight requests; responses arriving later are not accepted until the next config.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: CfgVld latches K (0 forced to 1) and Np, and clears the counters.
  - IDLE -> RUN on CfgVld when Np != 0; IDLE -> DONE on CfgVld when Np == 0.
  - RUN -> DONE on the output handshake of point Np-1.
  - DONE lasts one cycle with POLCCU_Done = 1, then returns to IDLE.
- Address issue:
  - Combinational passthrough: POLMIF_AddrVld = RUN & MAPPOL_IdxVld & (outstd < MAX_OUTSTD) & (addr_cnt < Np*K).
  - POLMAP_IdxRdy = the same gating & MIFPOL_AddrRdy. No buffering, zero latency.
  - Np*K is computed at IDX_WIDTH+NBR_WIDTH bits.
- Outstanding counter:
  - +1 on address handshake, -1 on ofm handshake; unchanged when both happen in the same cycle.
  - Never exceeds MAX_OUTSTD and never underflows. An ofm arriving with outstd == 0 is an error; it is not accepted.
- Accumulate:
  - nbr_cnt counts 0..K-1.
  - nbr_cnt == 0: acc <= in. Otherwise acc <= per-channel max(acc, in), unsigned compare by default.
  - Final neighbour (nbr_cnt == K-1): out_reg <= max(acc, in), or in when K == 1; out_vld <= 1; nbr_cnt <= 0; pt_cnt increments on the output handshake.
- POLMIF_OfmRdy = RUN & (outstd != 0) & ((nbr_cnt != K-1) | !out_vld | GLBPOL_OfmRdy).
  - Gives full throughput; back-to-back pooled outputs are possible when K == 1.
- Output register: holds stable while out_vld & !GLBPOL_OfmRdy. Latency from final ofm handshake to POLGLB_OfmVld is 1 cycle.
- CfgVld outside IDLE is ignored.

Optional Feature:
- Macro POL_MAX_SIGNED_EN.
- Defined: max compare treats each ACT_WIDTH lane as two's-complement signed.
- Undefined: unsigned compare. Datapath width is unchanged either way.

Decomposition:
- Shared package holds:
  - state encoding IDLE/RUN/DONE;
  - ACT_WIDTH, POOL_COMP_CORE and NBR_WIDTH defaults;
  - the per-lane vector type.
- Sub-module vec_max: combinational, parameterised lane-wise max of two ACT_WIDTH*POOL_COMP_CORE vectors; honours POL_MAX_SIGNED_EN.

Test Plan:
- K=3, Np=2, idx 5,6,7,8,9,10; responses lane0 = 3,9,4 then 1,2,200 -> outputs lane0 = 9 then 200; Done pulse 1 cycle after the 2nd output handshake.
- K=1, Np=4, GLBPOL_OfmRdy = 1, responses every cycle -> 4 outputs on consecutive cycles, each equal to its input.
- MIFPOL_AddrRdy = 1 and ofm withheld -> exactly MAX_OUTSTD=4 addresses issued, then IdxRdy = 0 until the first ofm handshake.
- GLBPOL_OfmRdy = 0 with K=2 and a pending output -> first neighbour accepted, final neighbour stalled (OfmRdy = 0); out_reg stable until Rdy.
- Np=0 config -> Done pulse the cycle after CfgVld, no address issued. CCUPOL_Rst mid-layer -> IDLE, all outputs 0, CfgRdy = 1 the next cycle.
- POL_MAX_SIGNED_EN on, K=2, lane0 = 0x80 and 0x01 -> output 0x01; off -> output 0x80.

Source files
------------

// File: rtl/pol_max_unit_pkg.sv
// -----------------------------------------------------------------------------
// pol_max_unit_pkg
// Shared definitions for the max-pooling core: default widths, FSM state
// encoding and the per-lane activation vector type.
// Optional build macro: POL_MAX_SIGNED_EN (signed lane compare, see vec_max).
// No ports (package).
// -----------------------------------------------------------------------------
package pol_max_unit_pkg;

  localparam int DEF_IDX_WIDTH      = 10;
  localparam int DEF_ACT_WIDTH      = 8;
  localparam int DEF_POOL_COMP_CORE = 64;
  localparam int DEF_NBR_WIDTH      = 5;
  localparam int DEF_MAX_OUTSTD     = 4;

  // FSM encoding: IDLE -> RUN -> DONE -> IDLE
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [DEF_ACT_WIDTH-1:0] lane_t;
  typedef lane_t [DEF_POOL_COMP_CORE-1:0] vec_t;

endpackage

// File: rtl/pol_max_unit_if.sv
// -----------------------------------------------------------------------------
// pol_max_unit_if
// Bundles the config, index, address, ofm-return and pooled-output channels
// of one pooling core.
// Optional build macro: POL_MAX_SIGNED_EN (does not affect this interface).
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge
// where both valid and ready are high. Ready may depend combinationally on
// valid; a source holds valid and data stable until the transfer completes.
//
// Modports:
//   slave  - the pooling core (pol_max_unit)
//   master - its environment (CCU, neighbour map, arbiter/MIF, GLB)
// -----------------------------------------------------------------------------
interface pol_max_unit_if
  import pol_max_unit_pkg::*;
#(
  parameter int IDX_WIDTH      = DEF_IDX_WIDTH,
  parameter int ACT_WIDTH      = DEF_ACT_WIDTH,
  parameter int POOL_COMP_CORE = DEF_POOL_COMP_CORE,
  parameter int NBR_WIDTH      = DEF_NBR_WIDTH
) ();

  // layer config
  logic                                CCUPOL_CfgVld;
  logic [NBR_WIDTH-1:0]                CCUPOL_CfgK;
  logic [IDX_WIDTH-1:0]                CCUPOL_CfgNp;
  logic                                POLCCU_CfgRdy;
  logic                                POLCCU_Done;
  // neighbour index stream
  logic                                MAPPOL_IdxVld;
  logic [IDX_WIDTH-1:0]                MAPPOL_Idx;
  logic                                POLMAP_IdxRdy;
  // address request to arbiter
  logic                                POLMIF_AddrVld;
  logic [IDX_WIDTH-1:0]                POLMIF_Addr;
  logic                                MIFPOL_AddrRdy;
  // returned ofm vectors
  logic                                MIFPOL_OfmVld;
  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] MIFPOL_Ofm;
  logic                                POLMIF_OfmRdy;
  // pooled output to GLB
  logic                                POLGLB_OfmVld;
  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] POLGLB_Ofm;
  logic                                GLBPOL_OfmRdy;

  modport slave (
    input  CCUPOL_CfgVld, CCUPOL_CfgK, CCUPOL_CfgNp,
    output POLCCU_CfgRdy, POLCCU_Done,
    input  MAPPOL_IdxVld, MAPPOL_Idx,
    output POLMAP_IdxRdy,
    output POLMIF_AddrVld, POLMIF_Addr,
    input  MIFPOL_AddrRdy,
    input  MIFPOL_OfmVld, MIFPOL_Ofm,
    output POLMIF_OfmRdy,
    output POLGLB_OfmVld, POLGLB_Ofm,
    input  GLBPOL_OfmRdy
  );

  modport master (
    output CCUPOL_CfgVld, CCUPOL_CfgK, CCUPOL_CfgNp,
    input  POLCCU_CfgRdy, POLCCU_Done,
    output MAPPOL_IdxVld, MAPPOL_Idx,
    input  POLMAP_IdxRdy,
    input  POLMIF_AddrVld, POLMIF_Addr,
    output MIFPOL_AddrRdy,
    output MIFPOL_OfmVld, MIFPOL_Ofm,
    input  POLMIF_OfmRdy,
    input  POLGLB_OfmVld, POLGLB_Ofm,
    output GLBPOL_OfmRdy
  );

endinterface

// File: rtl/pol_max_unit_vec_max.sv
// -----------------------------------------------------------------------------
// pol_max_unit_vec_max
// Combinational lane-wise max of two packed activation vectors.
// Optional build macro: POL_MAX_SIGNED_EN - when defined each ACT_WIDTH lane
// is compared as two's-complement signed, otherwise unsigned.
// Ports:
//   a, b : input vectors, ACT_WIDTH*POOL_COMP_CORE bits, lane i at [i*ACT_WIDTH +: ACT_WIDTH]
//   y    : per-lane max(a, b)
// -----------------------------------------------------------------------------
module pol_max_unit_vec_max
  import pol_max_unit_pkg::*;
#(
  parameter int ACT_WIDTH      = DEF_ACT_WIDTH,
  parameter int POOL_COMP_CORE = DEF_POOL_COMP_CORE
) (
  input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] a,
  input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] b,
  output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] y
);

  for (genvar i = 0; i < POOL_COMP_CORE; i++) begin : g_lane
    logic [ACT_WIDTH-1:0] la;
    logic [ACT_WIDTH-1:0] lb;
    logic                 a_gt;

    assign la = a[i*ACT_WIDTH +: ACT_WIDTH];
    assign lb = b[i*ACT_WIDTH +: ACT_WIDTH];
`ifdef POL_MAX_SIGNED_EN
    assign a_gt = $signed(la) > $signed(lb);
`else
    assign a_gt = la > lb;
`endif
    assign y[i*ACT_WIDTH +: ACT_WIDTH] = a_gt ? la : lb;
  end

endmodule

// File: rtl/pol_max_unit.sv
// -----------------------------------------------------------------------------
// pol_max_unit
// One max-pooling core. Forwards each neighbour index as a GLB address
// request (zero-latency passthrough), consumes the returned ofm vectors in
// order, reduces every group of K neighbours with a channel-wise max and
// emits one pooled vector per output point.
// Optional build macro: POL_MAX_SIGNED_EN (signed lane compare in vec_max).
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   CCUPOL_Rst - synchronous clear, same effect as reset
//   bus        - pol_max_unit_if.slave: config, index, address, ofm, output
//   dbg_state  - current FSM state (ST_IDLE/ST_RUN/ST_DONE)
// -----------------------------------------------------------------------------
module pol_max_unit
  import pol_max_unit_pkg::*;
#(
  parameter int IDX_WIDTH      = DEF_IDX_WIDTH,
  parameter int ACT_WIDTH      = DEF_ACT_WIDTH,
  parameter int POOL_COMP_CORE = DEF_POOL_COMP_CORE,
  parameter int NBR_WIDTH      = DEF_NBR_WIDTH,
  parameter int MAX_OUTSTD     = DEF_MAX_OUTSTD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CCUPOL_Rst,
  pol_max_unit_if.slave bus,
  output logic [1:0]    dbg_state
);

  localparam int VW = ACT_WIDTH * POOL_COMP_CORE;
  localparam int TW = IDX_WIDTH + NBR_WIDTH;
  localparam int OW = $clog2(MAX_OUTSTD + 1);
  localparam logic [OW-1:0] OUTSTD_MAX = OW'(MAX_OUTSTD);

  logic [1:0]           state;
  logic [NBR_WIDTH-1:0] k_r;
  logic [NBR_WIDTH-1:0] nbr_cnt;
  logic [IDX_WIDTH-1:0] np_r;
  logic [IDX_WIDTH-1:0] pt_cnt;
  logic [TW-1:0]        addr_cnt;
  logic [TW-1:0]        total_nk;
  logic [OW-1:0]        outstd;
  logic [VW-1:0]        acc;
  logic [VW-1:0]        out_reg;
  logic [VW-1:0]        max_acc_in;
  logic                 out_vld;

  logic run;
  logic addr_gate;
  logic addr_hs;
  logic last_nbr;
  logic last_pt;
  logic ofm_rdy;
  logic ofm_hs;
  logic out_hs;

  // Total number of neighbour fetches in the layer; full-width product.
  assign total_nk = TW'(np_r) * TW'(k_r);

  assign run      = (state == ST_RUN);
  assign last_nbr = (nbr_cnt == k_r - NBR_WIDTH'(1));
  assign last_pt  = (pt_cnt == np_r - IDX_WIDTH'(1));

  // Address issue is a pure passthrough of the index channel, throttled by
  // the in-flight limit and the layer's total fetch count.
  assign addr_gate = run & bus.MAPPOL_IdxVld & (outstd < OUTSTD_MAX) & (addr_cnt < total_nk);
  assign addr_hs   = addr_gate & bus.MIFPOL_AddrRdy;

  assign bus.POLMIF_AddrVld = addr_gate;
  assign bus.POLMIF_Addr    = bus.MAPPOL_Idx;
  assign bus.POLMAP_IdxRdy  = addr_hs;

  // The final neighbour of a point may only be taken when the output
  // register is free or being drained this cycle; earlier neighbours only
  // touch the accumulator and are always accepted. outstd != 0 guards
  // against responses with no matching request.
  assign ofm_rdy = run & (outstd != '0) & (~last_nbr | ~out_vld | bus.GLBPOL_OfmRdy);
  assign ofm_hs  = ofm_rdy & bus.MIFPOL_OfmVld;
  assign out_hs  = out_vld & bus.GLBPOL_OfmRdy;

  assign bus.POLMIF_OfmRdy = ofm_rdy;
  assign bus.POLGLB_OfmVld = out_vld;
  assign bus.POLGLB_Ofm    = out_reg;
  assign bus.POLCCU_CfgRdy = (state == ST_IDLE);
  assign bus.POLCCU_Done   = (state == ST_DONE);
  assign dbg_state         = state;

  pol_max_unit_vec_max #(
    .ACT_WIDTH      (ACT_WIDTH),
    .POOL_COMP_CORE (POOL_COMP_CORE)
  ) u_vec_max (
    .a (acc),
    .b (bus.MIFPOL_Ofm),
    .y (max_acc_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      k_r      <= NBR_WIDTH'(1);
      np_r     <= '0;
      nbr_cnt  <= '0;
      pt_cnt   <= '0;
      addr_cnt <= '0;
      outstd   <= '0;
      acc      <= '0;
      out_reg  <= '0;
      out_vld  <= 1'b0;
    end else if (CCUPOL_Rst) begin
      state    <= ST_IDLE;
      k_r      <= NBR_WIDTH'(1);
      np_r     <= '0;
      nbr_cnt  <= '0;
      pt_cnt   <= '0;
      addr_cnt <= '0;
      outstd   <= '0;
      acc      <= '0;
      out_reg  <= '0;
      out_vld  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.CCUPOL_CfgVld) begin
            // K == 0 degenerates to "no pooling", i.e. K == 1
            k_r      <= (bus.CCUPOL_CfgK == '0) ? NBR_WIDTH'(1) : bus.CCUPOL_CfgK;
            np_r     <= bus.CCUPOL_CfgNp;
            nbr_cnt  <= '0;
            pt_cnt   <= '0;
            addr_cnt <= '0;
            outstd   <= '0;
            out_vld  <= 1'b0;
            state    <= (bus.CCUPOL_CfgNp == '0) ? ST_DONE : ST_RUN;
          end
        end

        ST_RUN: begin
          if (addr_hs) begin
            addr_cnt <= addr_cnt + TW'(1);
          end
          if (addr_hs && !ofm_hs) begin
            outstd <= outstd + OW'(1);
          end else if (!addr_hs && ofm_hs) begin
            outstd <= outstd - OW'(1);
          end

          if (ofm_hs) begin
            acc <= (nbr_cnt == '0) ? bus.MIFPOL_Ofm : max_acc_in;
            if (last_nbr) begin
              out_reg <= (nbr_cnt == '0) ? bus.MIFPOL_Ofm : max_acc_in;
              nbr_cnt <= '0;
            end else begin
              nbr_cnt <= nbr_cnt + NBR_WIDTH'(1);
            end
          end

          // A new result loaded in the same cycle the old one drains keeps
          // the register valid.
          if (ofm_hs && last_nbr) begin
            out_vld <= 1'b1;
          end else if (out_hs) begin
            out_vld <= 1'b0;
          end

          if (out_hs) begin
            pt_cnt <= pt_cnt + IDX_WIDTH'(1);
            if (last_pt) begin
              state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
